audio_dac_serializer: RTL and testbench
=======================================

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, gives the bits per channel sample; the legal range is 8..32.
REQ-002 Parameter FIFO_DEPTH, default 8, gives the number of stereo sample pairs buffered; it SHALL be a power of 2, 2..256.
REQ-003 Parameter I2S_MODE, default 1: 1 selects I2S framing (one-BCLK MSB delay), 0 selects left-justified framing.
REQ-004 Port clk, in, 1: system clock; every register is clocked on its rising edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port s_data, in, 2*DATA_WIDTH: sample pair, left channel in the upper half, right channel in the lower half.
REQ-007 Port s_valid, in, 1: s_data is valid.
REQ-008 Port s_ready, out, 1: the block accepts s_data this cycle.
REQ-009 Port bclk, in, 1: codec bit clock (codec is master), asynchronous to clk.
REQ-010 Port daclrck, in, 1: codec LR clock (low = left channel), asynchronous to clk.
REQ-011 Port dacdat, out, 1: serial DAC data to the codec.
REQ-012 Port fifo_level, out, $clog2(FIFO_DEPTH)+1: number of pairs currently stored.
REQ-013 Port underrun, out, 1: one-clk pulse when a left frame starts with the FIFO empty.

Function
REQ-014 bclk and daclrck SHALL each pass through a 2-flop synchronizer followed by an edge-detect register; all behaviour below is driven by these detected edges.
REQ-015 s_ready SHALL equal !full; a push occurs when s_valid && s_ready.
REQ-016 A simultaneous push and pop SHALL keep fifo_level unchanged; when full, a same-cycle pop SHALL NOT admit a push.
REQ-017 On a daclrck falling edge with the FIFO non-empty, the block SHALL pop one pair, load the left half into the shift register, and hold the right half in a right-channel latch.
REQ-018 On a daclrck falling edge with the FIFO empty, the block SHALL load zeros into the shift register and the right-channel latch and pulse underrun for one cycle.
REQ-019 On a daclrck rising edge, the block SHALL load the right-channel latch into the shift register.
REQ-020 The shifter SHALL be a state machine with states IDLE, DELAY and SHIFT.
REQ-021 IDLE -> DELAY on a load when I2S_MODE=1; IDLE -> SHIFT on a load when I2S_MODE=0.
REQ-022 DELAY -> SHIFT on the next bclk falling edge, with dacdat held at 0 while in DELAY.
REQ-023 In SHIFT, dacdat SHALL present the MSB of the shift register, shifting left by one bit on each bclk falling edge.
REQ-024 After DATA_WIDTH bits have been presented, the FSM SHALL return to IDLE and dacdat SHALL be 0.
REQ-025 A daclrck edge arriving in any state SHALL abort the current word and reload per REQ-017..019 (handles short frames and resync).
REQ-026 A bit counter of width $clog2(DATA_WIDTH)+1 SHALL count presented bits; it SHALL NOT wrap past DATA_WIDTH.
REQ-027 Pushes SHALL have no latency constraint relative to the codec frame; data reaches dacdat at the next left-frame start at the earliest.

Reset
REQ-028 Reset SHALL drive dacdat=0, underrun=0, fifo_level=0 and s_ready=1, put the FSM in IDLE, and clear the synchronizers, shift register, latch and pointers.
REQ-029 After reset, no data SHALL be output until the first detected daclrck falling edge.
REQ-030 Reset asserted mid-word SHALL flush the FIFO and discard the word in flight.

Configuration
REQ-031 With macro AUDIO_DAC_UNDERRUN_COUNT_EN defined, an output underrun_count[15:0] SHALL exist: reset to 0, incremented on each underrun pulse, saturating at 16'hFFFF.
REQ-032 Without AUDIO_DAC_UNDERRUN_COUNT_EN, neither the port nor the counter SHALL exist; all other behaviour is identical.

Verification
REQ-033 Scenario: DATA_WIDTH=16, I2S; push 32'hA5A5_3C3C; run one frame -> left bits are 0 then 1010010110100101, right bits are 0 then 0011110000111100.
REQ-034 Scenario: I2S_MODE=0; push 32'h8000_0001 -> the MSB of left is 1 on the first bclk fall after daclrck falls, and the right LSB is 1 at bit 16.
REQ-035 Scenario: FIFO_DEPTH=4 with no codec clocks; push 5 pairs -> s_ready goes low after the 4th push and fifo_level=4.
REQ-036 Scenario: empty FIFO; 2 frames -> dacdat stays 0, 2 underrun pulses occur, and underrun_count=2 with the macro defined.
REQ-037 Scenario: full FIFO with s_valid high when daclrck falls -> fifo_level goes 4->3 and the push is accepted on the next cycle.
REQ-038 Scenario: reset asserted at bit 7 of the left word -> dacdat=0 next clk, fifo_level=0, and output resumes only after the next daclrck falling edge following a new push.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers stereo sample pairs from the clk domain and
// shifts them out to a codec that is bit-clock master (bclk/daclrck).
// Framing: I2S (one-BCLK MSB delay) or left-justified, selected by I2S_MODE.
// Optional feature macro: AUDIO_DAC_UNDERRUN_COUNT_EN adds underrun_count[15:0].
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int I2S_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*DATA_WIDTH-1:0]       s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          bclk,
  input  logic                          daclrck,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT
  } state_t;

  // ---------------------------------------------------------------------------
  // Codec clock synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic       bclk_prev;
  logic       lrck_prev;
  logic       bclk_fall;
  logic       lrck_fall;
  logic       lrck_rise;

  // Two-flop synchronizers followed by one edge-detect register per clock
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], daclrck};
      bclk_prev <= bclk_sync[1];
      lrck_prev <= lrck_sync[1];
    end
  end

  assign bclk_fall = bclk_prev & ~bclk_sync[1];
  assign lrck_fall = lrck_prev & ~lrck_sync[1];
  assign lrck_rise = ~lrck_prev & lrck_sync[1];

  // ---------------------------------------------------------------------------
  // Sample-pair FIFO
  // ---------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign s_ready = !full;
  // A pop frees a slot only after this cycle, so a full FIFO never admits a
  // push in the same cycle as the pop.
  assign push    = s_valid && !full;
  assign pop     = lrck_fall && !empty;
  assign rd_data = mem[rd_ptr];

  assign fifo_level = count;

  // Storage array, written on every accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------------------
  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shift_next;
  logic [DATA_WIDTH-1:0]   right_latch;
  logic [DATA_WIDTH-1:0]   latch_next;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           cnt_next;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   left_word;
  logic [DATA_WIDTH-1:0]   right_word;

  assign load       = lrck_fall | lrck_rise;
  assign left_word  = empty ? '0 : rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign right_word = empty ? '0 : rd_data[DATA_WIDTH-1:0];
  assign load_word  = lrck_fall ? left_word : right_latch;

  // State, shift register, right-channel latch, bit counter and output data
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      right_latch <= '0;
      bit_cnt     <= '0;
      dacdat      <= 1'b0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      right_latch <= latch_next;
      bit_cnt     <= cnt_next;
      dacdat      <= (state_next == SHIFT) && shift_next[DATA_WIDTH-1];
    end
  end

  // Next-state logic; a daclrck edge aborts any word in flight and reloads
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    latch_next = right_latch;
    cnt_next   = bit_cnt;

    if (lrck_fall) begin
      latch_next = right_word;
    end

    if (load) begin
      shift_next = load_word;
      cnt_next   = '0;
      state_next = (I2S_MODE != 0) ? DELAY : SHIFT;
    end else if (bclk_fall) begin
      case (state)
        DELAY: begin
          state_next = SHIFT;
        end
        SHIFT: begin
          // Counter ends at DATA_WIDTH and holds there until the next load
          shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
          cnt_next   = bit_cnt + CNT_ONE;
          if (bit_cnt == LAST_BIT) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // One-cycle underrun pulse when a left frame starts with nothing to send
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else begin
      underrun <= lrck_fall && empty;
    end
  end

`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
  // Saturating count of underrun pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`else
  // Underrun counting disabled: no counter and no port.
`endif

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: one I2S and one left-justified instance share
// all inputs; a queue-based model predicts each frame's serial bits.
module tb_audio_dac_serializer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int BPC   = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        bclk;
  logic        daclrck;
  logic        s_ready0, s_ready1;
  logic        dacdat0, dacdat1;
  logic        underrun0, underrun1;
  logic [2:0]  lvl0, lvl1;
`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
  logic [15:0] ucount0, ucount1;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int un_obs0 = 0;
  int un_obs1 = 0;
  int un_model = 0;
  int un_model_rst = 0;
  logic [31:0] q[$];

  logic [BPC-1:0] cap_l0, cap_r0, cap_l1, cap_r1;

  always #5 clk = ~clk;

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1)) dut_i2s (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat0), .fifo_level(lvl0),
    .underrun(underrun0)
`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
    , .underrun_count(ucount0)
`endif
  );

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(0)) dut_lj (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat1), .fifo_level(lvl1),
    .underrun(underrun1)
`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
    , .underrun_count(ucount1)
`endif
  );

  // Count underrun pulses seen on each instance
  always @(posedge clk) begin
    if (underrun0) un_obs0 <= un_obs0 + 1;
    if (underrun1) un_obs1 <= un_obs1 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample i of a channel half: word MSB first, starting d bit clocks in
  function automatic logic [BPC-1:0] exp_half(input logic [DW-1:0] w, input int d);
    logic [BPC-1:0] v;
    v = '0;
    for (int i = 0; i < DW; i++) v[i + d] = w[DW-1-i];
    return v;
  endfunction

  task automatic push(input logic [31:0] d);
    logic acc;
    acc = (q.size() < DEPTH);
    s_data = d;
    s_valid = 1'b1;
    check("s_ready_i2s", 64'(s_ready0), 64'(acc));
    check("s_ready_lj", 64'(s_ready1), 64'(acc));
    check("level_before_push", 64'(lvl0), 64'(q.size()));
    #10;
    s_valid = 1'b0;
    if (acc) q.push_back(d);
  endtask

  // One stereo frame of BPC bit clocks per channel; dacdat sampled at bclk rise.
  // rst_at >= 0 pulses reset after that left-channel sample.
  task automatic run_frame(input int rst_at);
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < BPC; i++) begin
        bclk = 1'b0;
        if (i == 0) daclrck = (h == 1);
        #50;
        if (h == 0) begin
          cap_l0[i] = dacdat0;
          cap_l1[i] = dacdat1;
        end else begin
          cap_r0[i] = dacdat0;
          cap_r1[i] = dacdat1;
        end
        bclk = 1'b1;
        if (h == 0 && i == rst_at) begin
          reset = 1'b1;
          #10;
          reset = 1'b0;
          check("rst_dacdat_i2s", 64'(dacdat0), 64'(0));
          check("rst_dacdat_lj", 64'(dacdat1), 64'(0));
          check("rst_level", 64'(lvl0), 64'(0));
          check("rst_s_ready", 64'(s_ready0), 64'(1));
          #40;
        end else begin
          #50;
        end
      end
    end
  endtask

  task automatic frame_and_check(input int rst_at);
    logic [31:0]    pair;
    logic           under;
    logic [BPC-1:0] m;
    under = (q.size() == 0);
    pair = under ? 32'h0 : q.pop_front();
    run_frame(rst_at);
    for (int i = 0; i < BPC; i++) m[i] = (rst_at < 0) || (i <= rst_at);
    if (under) begin
      un_model++;
      un_model_rst++;
    end
    if (rst_at >= 0) begin
      q.delete();
      un_model_rst = 0;
    end
    check("left_i2s", 64'(cap_l0), 64'(exp_half(pair[31:16], 1) & m));
    check("left_lj", 64'(cap_l1), 64'(exp_half(pair[31:16], 0) & m));
    check("right_i2s", 64'(cap_r0), 64'((rst_at < 0) ? exp_half(pair[15:0], 1) : '0));
    check("right_lj", 64'(cap_r1), 64'((rst_at < 0) ? exp_half(pair[15:0], 0) : '0));
    check("underruns_i2s", 64'(un_obs0), 64'(un_model));
    check("underruns_lj", 64'(un_obs1), 64'(un_model));
`ifdef AUDIO_DAC_UNDERRUN_COUNT_EN
    check("underrun_count", 64'(ucount0), 64'(un_model_rst));
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    bclk = 1'b1;
    daclrck = 1'b1;
    #30;
    check("reset_dacdat", 64'(dacdat0), 64'(0));
    check("reset_underrun", 64'(underrun0), 64'(0));
    check("reset_level", 64'(lvl0), 64'(0));
    check("reset_s_ready", 64'(s_ready0), 64'(1));
    reset = 1'b0;
    #20;

    // Empty FIFO: two silent frames, two underruns
    frame_and_check(-1);
    frame_and_check(-1);

    // Directed words
    push(32'hA5A5_3C3C);
    frame_and_check(-1);
    push(32'h8000_0001);
    frame_and_check(-1);

    // Fill without codec activity; fifth push refused
    for (int k = 0; k < 5; k++) push($urandom);
    check("full_level", 64'(lvl0), 64'(DEPTH));
    check("full_s_ready", 64'(s_ready0), 64'(0));

    // Full FIFO with s_valid held while a left frame starts
    s_data = $urandom;
    s_valid = 1'b1;
    daclrck = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      #10;
      if (lvl0 != 3'(DEPTH)) seen = 1'b1;
    end
    check("pop_seen", 64'(seen), 64'(1));
    check("pop_level", 64'(lvl0), 64'(DEPTH - 1));
    check("pop_level_lj", 64'(lvl1), 64'(DEPTH - 1));
    check("pop_s_ready", 64'(s_ready0), 64'(1));
    #10;
    s_valid = 1'b0;
    check("refill_level", 64'(lvl0), 64'(DEPTH));
    check("refill_s_ready", 64'(s_ready0), 64'(0));
    void'(q.pop_front());
    q.push_back(s_data);
    daclrck = 1'b1;
    #50;

    // Drain, then one underrun frame
    while (q.size() > 0) frame_and_check(-1);
    frame_and_check(-1);

    // Reset in the middle of a left word, then silence until a new push
    push($urandom);
    push($urandom);
    frame_and_check(8);
    frame_and_check(-1);
    push(32'h1234_FEDC);
    frame_and_check(-1);

    // Random pushes and frame counts
    for (int it = 0; it < 6; it++) begin
      int n;
      int f;
      n = $urandom_range(0, DEPTH);
      f = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push($urandom);
      for (int k = 0; k < f; k++) frame_and_check(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
